dps_codec_16: RTL and testbench

// - 16-wire TSV crosstalk-avoidance (DPS) codec: maps a 12-bit data word onto a 16-bit

---
 rtl/dps_codec_16.sv | 133 +++++++++++++
 tb/tb_dps_codec_16.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dps_codec_16.sv
// 16-wire TSV crosstalk-avoidance codec: 12-bit rank <-> 16-bit word with no interior 1-bit run.
// Latency: encoder 1 cycle (registered tsv); decoder combinational from tsv_rx.
// Backpressure: none; a new data word is accepted on every rising clock edge.
module dps_codec_16 #(
  parameter int DBLEN16 = 12,
  parameter int TSVW    = 16,
  parameter int NCODE   = 3194
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DBLEN16-1:0] datain,
  output logic [TSVW-1:0]    tsv,
  input  logic [TSVW-1:0]    tsv_rx,
  output logic [DBLEN16-1:0] dataout,
  output logic               code_err
);

  // Highest legal rank; inputs above it saturate onto the all-ones codeword.
  localparam logic [DBLEN16-1:0] MAX_RANK = DBLEN16'(NCODE - 1);

  // Fibonacci numbers with Fib(1) = Fib(2) = 1; Fib(m+2) counts completions of
  // m bits from an unconstrained state, Fib(m+1) from a state forced to repeat.
  function automatic logic [DBLEN16-1:0] fib(input int n);
    logic [DBLEN16-1:0] f;
    case (n)
      1:       f = 12'd1;
      2:       f = 12'd1;
      3:       f = 12'd2;
      4:       f = 12'd3;
      5:       f = 12'd5;
      6:       f = 12'd8;
      7:       f = 12'd13;
      8:       f = 12'd21;
      9:       f = 12'd34;
      10:      f = 12'd55;
      11:      f = 12'd89;
      12:      f = 12'd144;
      13:      f = 12'd233;
      14:      f = 12'd377;
      15:      f = 12'd610;
      16:      f = 12'd987;
      17:      f = 12'd1597;
      default: f = 12'd0;
    endcase
    return f;
  endfunction

  logic [DBLEN16-1:0] enc_rem;
  logic [DBLEN16-1:0] enc_zc;
  logic               enc_prev;
  logic               enc_forced;
  logic               enc_bit;
  logic [TSVW-1:0]    tsv_d;
  logic [TSVW-1:0]    tsv_q;

  // Greedy MSB-first encoder: a bit is 1 when the remaining rank is at least the
  // number of words reachable by putting 0 there instead.
  always_comb begin
    enc_rem    = (datain > MAX_RANK) ? MAX_RANK : datain;
    enc_zc     = '0;
    enc_prev   = 1'b0;
    enc_forced = 1'b0;
    enc_bit    = 1'b0;
    tsv_d      = '0;
    for (int p = TSVW - 1; p >= 0; p--) begin
      // 0-branch size: bit15 always leaves a free state; otherwise a 0 after a 0
      // stays free (Fib(p+2)), a 0 after a 1 starts a 1-bit run (Fib(p+1)).
      if (p == TSVW - 1) begin
        enc_zc = fib(TSVW + 1);
      end else if (enc_prev) begin
        enc_zc = fib(p + 1);
      end else begin
        enc_zc = fib(p + 2);
      end
      // A 1-bit interior run must be extended, so a forced bit just repeats.
      if (enc_forced) begin
        enc_bit = enc_prev;
      end else begin
        enc_bit = (enc_rem >= enc_zc);
        if (enc_bit) begin
          enc_rem = enc_rem - enc_zc;
        end
      end
      tsv_d[p]   = enc_bit;
      enc_forced = (p != TSVW - 1) && (enc_bit != enc_prev);
      enc_prev   = enc_bit;
    end
  end

  // Codeword register driving the TSV bundle; reset loads the codeword of rank 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      tsv_q <= '0;
    end else begin
      tsv_q <= tsv_d;
    end
  end

  assign tsv = tsv_q;

  logic [TSVW:0]      rx_ext;
  logic               rx_legal;
  logic [DBLEN16-1:0] rx_rank;

  // Decoder: check for interior 1-bit runs and sum the 0-branch sizes at every 1.
  always_comb begin
    // Replicating bit15 above the word makes bit14 see the top wire as a
    // run of at least two, matching the free state that follows bit15.
    rx_ext   = {tsv_rx[TSVW-1], tsv_rx};
    rx_legal = 1'b1;
    rx_rank  = '0;
    for (int i = 1; i < TSVW - 1; i++) begin
      if ((tsv_rx[i] != tsv_rx[i-1]) && (tsv_rx[i] != tsv_rx[i+1])) begin
        rx_legal = 1'b0;
      end
    end
    if (tsv_rx[TSVW-1]) begin
      rx_rank = fib(TSVW + 1);
    end
    for (int p = TSVW - 2; p >= 0; p--) begin
      if (tsv_rx[p]) begin
        if (!rx_ext[p+1]) begin
          rx_rank = rx_rank + fib(p + 2);
        end else if (rx_ext[p+2]) begin
          rx_rank = rx_rank + fib(p + 1);
        end
      end
    end
    code_err = !rx_legal || (rx_rank > MAX_RANK);
    dataout  = code_err ? '1 : rx_rank;
  end

endmodule

// File: tb/tb_dps_codec_16.sv
// Directed bench for dps_codec_16: reset, anchors, exhaustive loopback, random, range, illegal rx.
// Reference codewords come from a brute-force enumeration of all 16-bit words.
// Drives one word per cycle; outputs are sampled 1 time unit after the rising edge.
module tb_dps_codec_16;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] datain;
  logic [15:0] tsv;
  logic [15:0] tsv_rx;
  logic [11:0] dataout;
  logic        code_err;

  logic        loop_en;
  logic [15:0] rx_drv;

  int checks = 0;
  int errors = 0;

  logic [15:0] code_tab [3194];

  assign tsv_rx = loop_en ? tsv : rx_drv;

  dps_codec_16 dut (
    .clock   (clock),
    .reset   (reset),
    .datain  (datain),
    .tsv     (tsv),
    .tsv_rx  (tsv_rx),
    .dataout (dataout),
    .code_err(code_err)
  );

  always #5 clock = ~clock;

  // Independent legality test: no 010 or 101 in any 3-bit window.
  function automatic bit no_bad_window(input logic [15:0] w);
    logic [2:0] win;
    bit ok = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      win = w[j +: 3];
      if (win == 3'b010 || win == 3'b101) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [11:0] d, input logic r);
    datain = d;
    reset  = r;
    @(posedge clock);
    #1;
  endtask

  int n;
  logic [15:0] prev_tsv;
  logic [11:0] rd;

  initial begin
    // Build the reference table: the d-th legal word in ascending order.
    n = 0;
    for (int w = 0; w < 65536; w++) begin
      if (no_bad_window(16'(w))) begin
        if (n < 3194) code_tab[n] = 16'(w);
        n++;
      end
    end
    chk("legal_count", 16'(n), 16'd3194);

    loop_en = 1'b1;
    rx_drv  = 16'h0000;
    datain  = 12'd1234;
    reset   = 1'b1;

    // Reset overrides datain.
    step(12'd1234, 1'b1);
    chk("reset_tsv", tsv, 16'h0000);
    chk("reset_dataout", {4'h0, dataout}, 16'd0);
    chk("reset_err", {15'h0, code_err}, 16'd0);

    // Anchor codewords.
    step(12'd0, 1'b0);    chk("anchor_0", tsv, 16'h0000);
    step(12'd1, 1'b0);    chk("anchor_1", tsv, 16'h0001);
    step(12'd2, 1'b0);    chk("anchor_2", tsv, 16'h0003);
    step(12'd3, 1'b0);    chk("anchor_3", tsv, 16'h0006);
    step(12'd1596, 1'b0); chk("anchor_1596", tsv, 16'h7FFF);
    chk("anchor_1596_rx", {4'h0, dataout}, 16'd1596);
    step(12'd1597, 1'b0); chk("anchor_1597", tsv, 16'h8000);
    chk("anchor_1597_rx", {4'h0, dataout}, 16'd1597);
    step(12'd3193, 1'b0); chk("anchor_3193", tsv, 16'hFFFF);
    chk("anchor_3193_rx", {4'h0, dataout}, 16'd3193);

    // Mid-stream reset discards the in-flight word.
    step(12'd500, 1'b0);  chk("pre_reset", tsv, code_tab[500]);
    step(12'd700, 1'b1);  chk("mid_reset", tsv, 16'h0000);

    // Exhaustive loopback in ascending order; strictly increasing tsv implies distinct.
    prev_tsv = 16'h0000;
    for (int d = 0; d < 3194; d++) begin
      step(12'(d), 1'b0);
      chk($sformatf("exh_tsv_%0d", d), tsv, code_tab[d]);
      chk($sformatf("exh_rx_%0d", d), {4'h0, dataout}, 16'(d));
      chk($sformatf("exh_err_%0d", d), {15'h0, code_err}, 16'd0);
      chk($sformatf("exh_win_%0d", d), {15'h0, no_bad_window(tsv)}, 16'd1);
      if (d > 0) chk($sformatf("exh_order_%0d", d), {15'h0, (tsv > prev_tsv)}, 16'd1);
      prev_tsv = tsv;
    end

    // Random words.
    for (int k = 0; k < 3000; k++) begin
      rd = 12'($urandom_range(0, 3193));
      step(rd, 1'b0);
      chk($sformatf("rnd_tsv_%0d", rd), tsv, code_tab[rd]);
      chk($sformatf("rnd_rx_%0d", rd), {4'h0, dataout}, {4'h0, rd});
    end

    // Out-of-range inputs saturate.
    step(12'd3194, 1'b0);
    chk("oor_3194_tsv", tsv, 16'hFFFF);
    chk("oor_3194_rx", {4'h0, dataout}, 16'd3193);
    step(12'd4095, 1'b0);
    chk("oor_4095_tsv", tsv, 16'hFFFF);
    chk("oor_4095_rx", {4'h0, dataout}, 16'd3193);

    // Direct receive path, including illegal words.
    loop_en = 1'b0;
    rx_drv  = 16'h0002; #1;
    chk("ill_0002_err", {15'h0, code_err}, 16'd1);
    chk("ill_0002_rx", {4'h0, dataout}, 16'h0FFF);
    rx_drv  = 16'h5555; #1;
    chk("ill_5555_err", {15'h0, code_err}, 16'd1);
    chk("ill_5555_rx", {4'h0, dataout}, 16'h0FFF);
    rx_drv  = 16'h8001; #1;
    chk("rx_8001_err", {15'h0, code_err}, 16'd0);
    chk("rx_8001_rx", {4'h0, dataout}, 16'd1598);
    rx_drv  = 16'h4000; #1;
    chk("ill_4000_err", {15'h0, code_err}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
